// File: rtl/startup_display_pkg.sv
// startup_display_pkg: shared widths, shifter states, majority voter and default pattern table
package startup_display_pkg;
    localparam int PAT_W = 16;
    localparam int ADR_W = 8;

    typedef enum logic [1:0] {IDLE, LO, HI, LATCH} sh_state_e;

    function automatic logic [15:0] maj3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // walking-one table; indices past the pattern width fall off to zero
    function automatic logic [PAT_W-1:0] default_pat(input logic [ADR_W-1:0] i);
        return PAT_W'(1) << i;
    endfunction
endpackage

// File: rtl/startup_pattern_rom.sv
// startup_pattern_rom: combinational pattern lookup, addresses at or beyond NPAT read as zero
module startup_pattern_rom
    import startup_display_pkg::*;
#(
    parameter int NPAT = 8
) (
    input  logic [ADR_W-1:0] adr,
    output logic [PAT_W-1:0] pat
);
    always_comb pat = (32'(adr) < NPAT) ? default_pat(adr) : '0;
endmodule

// File: rtl/startup_display_driver.sv
// startup_display_driver: sequencer responder with triplicated control state that shifts ROM patterns to a serial LED driver
module startup_display_driver
    import startup_display_pkg::*;
#(
    parameter int NPAT   = 8,
    parameter int CLKDIV = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLEAR,
    input  logic        DISP,
    input  logic        LOAD_PAT,
    input  logic        NXT_ADR,
    input  logic        RST_TMR,
    output logic [15:0] TMR,
    output logic        DONE,
    output logic        BUSY,
    output logic        SER_DATA,
    output logic        SER_CLK,
    output logic        SER_LATCH,
    output logic        SER_CLR,
    output logic        BLANK
);
    logic [2:0][15:0]      tmr_q;
    logic [2:0][ADR_W-1:0] addr_q;
    logic [2:0][1:0]       state_q;
    logic [2:0][3:0]       bit_q;
    logic [2:0][7:0]       phase_q;
    logic [15:0]           tmr_d, tmr_v;
    logic [ADR_W-1:0]      addr_d, addr_v;
    sh_state_e             state_d, state_v;
    logic [3:0]            bit_d, bit_v;
    logic [7:0]            phase_d, phase_v;
    logic [PAT_W-1:0]      shreg_q, shreg_d, rom_pat;
    logic                  ser_data_q, ser_data_d;
    logic                  ser_clk_q, ser_clk_d;
    logic                  ser_latch_q, ser_latch_d;
    logic                  ser_clr_q, ser_clr_d;
    logic                  blank_q, blank_d;
    logic                  done, load, last_ph;

    startup_pattern_rom #(.NPAT(NPAT)) u_rom (.adr(addr_v), .pat(rom_pat));

    always_comb begin
        tmr_v   = maj3(tmr_q[0], tmr_q[1], tmr_q[2]);
        addr_v  = ADR_W'(maj3(16'(addr_q[0]), 16'(addr_q[1]), 16'(addr_q[2])));
        state_v = sh_state_e'(2'(maj3(16'(state_q[0]), 16'(state_q[1]), 16'(state_q[2]))));
        bit_v   = 4'(maj3(16'(bit_q[0]), 16'(bit_q[1]), 16'(bit_q[2])));
        phase_v = 8'(maj3(16'(phase_q[0]), 16'(phase_q[1]), 16'(phase_q[2])));
        done    = addr_v == ADR_W'(NPAT);
        load    = LOAD_PAT && state_v == IDLE && !done && !CLEAR;
        last_ph = phase_v == 8'(CLKDIV - 1);
        tmr_d   = RST_TMR ? '0 : (tmr_v == 16'hFFFF ? tmr_v : tmr_v + 16'd1);
        addr_d  = CLEAR ? '0 : (NXT_ADR && !done ? addr_v + 1'b1 : addr_v);
        shreg_d = load ? rom_pat : shreg_q;
        state_d = state_v;
        bit_d   = bit_v;
        phase_d = last_ph ? '0 : phase_v + 8'd1;
        case (state_v)
            IDLE: begin
                phase_d = '0;
                if (load) begin
                    state_d = LO;
                    bit_d   = '0;
                end
            end
            LO: if (last_ph) state_d = HI;
            HI: if (last_ph) begin
                state_d = bit_v == 4'd15 ? LATCH : LO;
                bit_d   = bit_v + 4'd1;
            end
            default: if (last_ph) state_d = IDLE;
        endcase
        if (CLEAR) begin
            state_d = IDLE;
            bit_d   = '0;
            phase_d = '0;
        end
        // serial outputs are registered from the next state so they align with it
        ser_data_d  = (state_d == LO || state_d == HI) ? shreg_d[~bit_d] : 1'b0;
        ser_clk_d   = state_d == HI;
        ser_latch_d = state_d == LATCH;
        ser_clr_d   = CLEAR;
        blank_d     = ~DISP;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmr_q       <= '0;
            addr_q      <= '0;
            state_q     <= '0;
            bit_q       <= '0;
            phase_q     <= '0;
            shreg_q     <= '0;
            ser_data_q  <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_latch_q <= 1'b0;
            ser_clr_q   <= 1'b1;
            blank_q     <= 1'b1;
        end else begin
            tmr_q       <= {3{tmr_d}};
            addr_q      <= {3{addr_d}};
            state_q     <= {3{state_d}};
            bit_q       <= {3{bit_d}};
            phase_q     <= {3{phase_d}};
            shreg_q     <= shreg_d;
            ser_data_q  <= ser_data_d;
            ser_clk_q   <= ser_clk_d;
            ser_latch_q <= ser_latch_d;
            ser_clr_q   <= ser_clr_d;
            blank_q     <= blank_d;
        end
    end

    assign TMR       = tmr_v;
    assign DONE      = done;
    assign BUSY      = state_v != IDLE;
    assign SER_DATA  = ser_data_q;
    assign SER_CLK   = ser_clk_q;
    assign SER_LATCH = ser_latch_q;
    assign SER_CLR   = ser_clr_q;
    assign BLANK     = blank_q;
endmodule

// File: tb/tb_startup_display_driver.sv
// tb_startup_display_driver: randomized scenario bench against a cycle-offset model of the serial stream
module tb_startup_display_driver;
    localparam int C = 4;

    logic        CLK, RST, CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TMR;
    logic [15:0] TMR;
    logic        DONE, BUSY, SER_DATA, SER_CLK, SER_LATCH, SER_CLR, BLANK;
    int          checks = 0;
    int          failures = 0;

    startup_display_driver #(.NPAT(8), .CLKDIV(C)) dut (
        .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .DISP(DISP), .LOAD_PAT(LOAD_PAT),
        .NXT_ADR(NXT_ADR), .RST_TMR(RST_TMR), .TMR(TMR), .DONE(DONE), .BUSY(BUSY),
        .SER_DATA(SER_DATA), .SER_CLK(SER_CLK), .SER_LATCH(SER_LATCH),
        .SER_CLR(SER_CLR), .BLANK(BLANK)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // expected {BUSY, SER_DATA, SER_CLK, SER_LATCH} t cycles after an accepted load
    function automatic logic [3:0] exp_sig(input logic [15:0] pat, input int t);
        int k;
        if (t < 1 || t > 33 * C) return 4'b0000;
        k = (t - 1) / (2 * C);
        if (k >= 16) return 4'b1001;
        return {1'b1, pat[15 - k], ((t - 1) % (2 * C)) >= C, 1'b0};
    endfunction

    task automatic goto_addr(input int a);
        CLEAR = 1;
        tick();
        CLEAR = 0;
        repeat (a) begin
            NXT_ADR = 1;
            tick();
        end
        NXT_ADR = 0;
    endtask

    task automatic test_reset();
        RST = 1; RST_TMR = 0; DISP = 1;
        tick();
        tick();
        checks++;
        if ({TMR, DONE, BUSY, SER_DATA, SER_CLK, SER_LATCH, SER_CLR, BLANK} !== {16'h0, 7'b0000011}) begin
            failures++;
            $display("FAIL reset_values got %h/%b want 0000/0000011", TMR, {DONE, BUSY, SER_DATA, SER_CLK, SER_LATCH, SER_CLR, BLANK});
        end
        RST = 0; RST_TMR = 1; DISP = 0;
        tick();
        checks++;
        if ({SER_CLR, TMR} !== 17'h0) begin
            failures++;
            $display("FAIL reset_release got clr=%b tmr=%h want clr=0 tmr=0", SER_CLR, TMR);
        end
    endtask

    task automatic test_tmr();
        int k;
        RST_TMR = 0;
        repeat (3000) tick();
        checks++;
        if (TMR !== 16'hBB8) begin failures++; $display("FAIL tmr_3000 got %h want 0bb8", TMR); end
        RST_TMR = 1;
        tick();
        checks++;
        if (TMR !== 16'h0) begin failures++; $display("FAIL tmr_clear got %h want 0000", TMR); end
        RST_TMR = 0;
        k = $urandom_range(1, 500);
        repeat (k) tick();
        checks++;
        if (TMR !== 16'(k)) begin failures++; $display("FAIL tmr_rand got %h want %h", TMR, 16'(k)); end
        repeat (70000) tick();
        checks++;
        if (TMR !== 16'hFFFF) begin failures++; $display("FAIL tmr_sat got %h want ffff", TMR); end
        tick();
        checks++;
        if (TMR !== 16'hFFFF) begin failures++; $display("FAIL tmr_sat_hold got %h want ffff", TMR); end
        RST_TMR = 1;
        tick();
        checks++;
        if (TMR !== 16'h0) begin failures++; $display("FAIL tmr_clear_sat got %h want 0000", TMR); end
    endtask

    task automatic test_blank();
        repeat (8) begin
            DISP = 1'($urandom);
            tick();
            checks++;
            if (BLANK !== ~DISP) begin failures++; $display("FAIL blank got %b want %b", BLANK, ~DISP); end
        end
    endtask

    task automatic test_shift();
        for (int i = 0; i < 5; i++) begin
            int a, rises, lat;
            logic [15:0] pat, word;
            logic prev;
            a = (i == 0) ? 2 : $urandom_range(0, 7);
            pat = 16'h1 << a;
            goto_addr(a);
            LOAD_PAT = 1;
            tick();
            LOAD_PAT = 0;
            rises = 0; lat = 0; word = 0; prev = 0;
            for (int t = 1; t <= 33 * C + 1; t++) begin
                checks++;
                if ({BUSY, SER_DATA, SER_CLK, SER_LATCH} !== exp_sig(pat, t)) begin
                    failures++;
                    $display("FAIL shift_stream a=%0d t=%0d got %b want %b", a, t, {BUSY, SER_DATA, SER_CLK, SER_LATCH}, exp_sig(pat, t));
                end
                if (SER_CLK && !prev) begin rises++; word = {word[14:0], SER_DATA}; end
                prev = SER_CLK;
                if (SER_LATCH) lat++;
                if (t <= 33 * C) tick();
            end
            checks++;
            if (rises != 16 || word !== pat) begin
                failures++;
                $display("FAIL shift_word got %0d edges %h want 16 edges %h", rises, word, pat);
            end
            checks++;
            if (lat != C) begin failures++; $display("FAIL shift_latch got %0d want %0d", lat, C); end
            checks++;
            if (BUSY !== 1'b0) begin failures++; $display("FAIL shift_busy_133 got %b want 0", BUSY); end
        end
    endtask

    task automatic test_done();
        goto_addr(0);
        for (int i = 1; i <= 9; i++) begin
            NXT_ADR = 1;
            tick();
            checks++;
            if (DONE !== (i >= 8)) begin failures++; $display("FAIL done_step%0d got %b want %b", i, DONE, i >= 8); end
        end
        NXT_ADR = 0;
        checks++;
        if (dut.addr_q !== {3{8'd8}}) begin failures++; $display("FAIL done_addr_sat got %h want 080808", dut.addr_q); end
        LOAD_PAT = 1;
        tick();
        LOAD_PAT = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({BUSY, SER_DATA, SER_CLK} !== 3'b000) begin
                failures++;
                $display("FAIL done_load_ignored got %b want 000", {BUSY, SER_DATA, SER_CLK});
            end
            tick();
        end
    endtask

    task automatic test_clear();
        int a, stop;
        logic [15:0] pat;
        a = $urandom_range(0, 7);
        pat = 16'h1 << a;
        goto_addr(a);
        LOAD_PAT = 1;
        tick();
        LOAD_PAT = 0;
        stop = 1 + 10 * C + $urandom_range(0, 2 * C - 1);
        for (int t = 1; t <= stop; t++) begin
            checks++;
            if ({BUSY, SER_DATA, SER_CLK, SER_LATCH} !== exp_sig(pat, t)) begin
                failures++;
                $display("FAIL clear_prefix t=%0d got %b want %b", t, {BUSY, SER_DATA, SER_CLK, SER_LATCH}, exp_sig(pat, t));
            end
            if (t < stop) tick();
        end
        CLEAR = 1;
        tick();
        CLEAR = 0;
        checks++;
        if ({BUSY, SER_CLK, SER_DATA, SER_LATCH, SER_CLR, DONE} !== 6'b000010) begin
            failures++;
            $display("FAIL clear_idle got %b want 000010", {BUSY, SER_CLK, SER_DATA, SER_LATCH, SER_CLR, DONE});
        end
        checks++;
        if (dut.addr_q !== '0) begin failures++; $display("FAIL clear_addr got %h want 000000", dut.addr_q); end
        tick();
        checks++;
        if ({SER_CLR, BUSY} !== 2'b00) begin failures++; $display("FAIL clear_release got %b want 00", {SER_CLR, BUSY}); end
    endtask

    task automatic test_back_to_back();
        int r;
        logic [15:0] word;
        logic prev;
        goto_addr(0);
        NXT_ADR = 1; LOAD_PAT = 1;
        tick();
        NXT_ADR = 0; LOAD_PAT = 0;
        r = $urandom_range(1, 33 * C - 1);
        for (int t = 1; t <= 33 * C + 1; t++) begin
            checks++;
            if ({BUSY, SER_DATA, SER_CLK, SER_LATCH} !== exp_sig(16'h0001, t)) begin
                failures++;
                $display("FAIL b2b_first t=%0d got %b want %b", t, {BUSY, SER_DATA, SER_CLK, SER_LATCH}, exp_sig(16'h0001, t));
            end
            LOAD_PAT = (t == r);
            if (t <= 33 * C) tick();
        end
        LOAD_PAT = 1;
        tick();
        LOAD_PAT = 0;
        word = 0; prev = 0;
        for (int t = 1; t <= 33 * C + 1; t++) begin
            checks++;
            if ({BUSY, SER_DATA, SER_CLK, SER_LATCH} !== exp_sig(16'h0002, t)) begin
                failures++;
                $display("FAIL b2b_second t=%0d got %b want %b", t, {BUSY, SER_DATA, SER_CLK, SER_LATCH}, exp_sig(16'h0002, t));
            end
            if (SER_CLK && !prev) word = {word[14:0], SER_DATA};
            prev = SER_CLK;
            if (t <= 33 * C) tick();
        end
        checks++;
        if (word !== 16'h0002) begin failures++; $display("FAIL b2b_word got %h want 0002", word); end
    endtask

    task automatic test_tmr_vote();
        logic [2:0][7:0] av;
        logic [2:0][1:0] sv;
        logic [15:0] word;
        logic prev;
        int r, j;
        goto_addr(3);
        for (int u = 0; u < 2; u++) begin
            j = $urandom_range(0, 2);
            av = {3{8'd3}};
            av[j] = (u == 0) ? 8'hFF : 8'd8;
            force dut.addr_q = av;
            #1;
            checks++;
            if (DONE !== 1'b0) begin failures++; $display("FAIL vote_done copy=%0d got %b want 0", j, DONE); end
            release dut.addr_q;
            tick();
            checks++;
            if (dut.addr_q !== {3{8'd3}}) begin failures++; $display("FAIL vote_addr_scrub got %h want 030303", dut.addr_q); end
        end
        LOAD_PAT = 1;
        tick();
        LOAD_PAT = 0;
        r = $urandom_range(5, 30 * C);
        word = 0; prev = 0;
        for (int t = 1; t <= 33 * C + 1; t++) begin
            checks++;
            if ({BUSY, SER_DATA, SER_CLK, SER_LATCH} !== exp_sig(16'h0008, t)) begin
                failures++;
                $display("FAIL vote_stream t=%0d got %b want %b", t, {BUSY, SER_DATA, SER_CLK, SER_LATCH}, exp_sig(16'h0008, t));
            end
            if (SER_CLK && !prev) word = {word[14:0], SER_DATA};
            prev = SER_CLK;
            if (t == r) begin
                sv = dut.state_q;
                j = $urandom_range(0, 2);
                sv[j] = sv[j] ^ 2'($urandom_range(1, 3));
                force dut.state_q = sv;
                #1;
                release dut.state_q;
            end
            if (t <= 33 * C) tick();
            if (t == r) begin
                checks++;
                if (dut.state_q[0] !== dut.state_q[1] || dut.state_q[1] !== dut.state_q[2]) begin
                    failures++;
                    $display("FAIL vote_state_scrub got %b want three equal copies", dut.state_q);
                end
            end
        end
        checks++;
        if (word !== 16'h0008) begin failures++; $display("FAIL vote_word got %h want 0008", word); end
    endtask

    initial begin
        CLK = 0; RST = 1; CLEAR = 0; DISP = 0; LOAD_PAT = 0; NXT_ADR = 0; RST_TMR = 1;
        test_reset();
        test_tmr();
        test_blank();
        test_shift();
        test_done();
        test_clear();
        test_back_to_back();
        test_tmr_vote();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
